// File: rtl/conv_layer_scheduler.sv
// Sequences one shared conv1d engine across NUM_LAYERS layers per input sample,
// with a per-layer completion watchdog and a saturating input-overrun counter.
module conv_layer_scheduler #(
    parameter int NUM_LAYERS = 3,
    parameter int LW         = 2,
    parameter int TIMEOUT    = 64,
    parameter int TW         = 7,
    parameter int CW         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_v,
    output logic                  in_ready,
    output logic                  lsb_shift,
    output logic                  conv_rst,
    output logic [LW-1:0]         conv_layer,
    output logic                  conv_relu,
    input  logic                  conv_out_v,
    output logic [NUM_LAYERS-2:0] cache_shift,
    output logic                  out_v,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [CW-1:0]         overrun_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_START,
        S_WAIT,
        S_CACHE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         layer_q, layer_d;
    logic [TW-1:0]         wdog_q, wdog_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         ovr_q, ovr_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  lsb_shift_q, lsb_shift_d;
    logic                  conv_rst_q, conv_rst_d;
    logic                  relu_q, relu_d;
    logic [NUM_LAYERS-2:0] cache_shift_q, cache_shift_d;
    logic                  out_v_q, out_v_d;

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        ovr_d   = ovr_q;

        case (state_q)
            S_IDLE: begin
                if (in_v) begin
                    state_d = S_SHIFT;
                    layer_d = '0;
                end
            end
            S_SHIFT: state_d = S_START;
            S_START: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion takes priority over the watchdog limit in the same cycle.
                if (conv_out_v) begin
                    state_d = (layer_q < LW'(NUM_LAYERS - 1)) ? S_CACHE : S_DONE;
                end else if (wdog_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_CACHE: begin
                layer_d = layer_q + 1'b1;
                state_d = S_START;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (in_v && (state_q != S_IDLE) && (ovr_q != '1)) begin
            ovr_d = ovr_q + 1'b1;
        end

        // Outputs are decoded from next state so they register alongside it.
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        lsb_shift_d = (state_d == S_SHIFT);
        conv_rst_d  = (state_d == S_START);
        out_v_d     = (state_d == S_DONE);
        relu_d      = (layer_d != LW'(NUM_LAYERS - 1));
        cache_shift_d = '0;
        for (int unsigned k = 0; k < NUM_LAYERS - 1; k++) begin
            cache_shift_d[k] = (state_d == S_CACHE) && (layer_d == LW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            layer_q       <= '0;
            wdog_q        <= '0;
            err_q         <= 1'b0;
            ovr_q         <= '0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            lsb_shift_q   <= 1'b0;
            conv_rst_q    <= 1'b0;
            relu_q        <= 1'b1;
            cache_shift_q <= '0;
            out_v_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            layer_q       <= layer_d;
            wdog_q        <= wdog_d;
            err_q         <= err_d;
            ovr_q         <= ovr_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            lsb_shift_q   <= lsb_shift_d;
            conv_rst_q    <= conv_rst_d;
            relu_q        <= relu_d;
            cache_shift_q <= cache_shift_d;
            out_v_q       <= out_v_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign lsb_shift   = lsb_shift_q;
    assign conv_rst    = conv_rst_q;
    assign conv_layer  = layer_q;
    assign conv_relu   = relu_q;
    assign cache_shift = cache_shift_q;
    assign out_v       = out_v_q;
    assign timeout_err = err_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Bench for conv_layer_scheduler: a frame-level timeline model plus literal spot checks.
module tb_conv_layer_scheduler;

    localparam int NC = 300;
    localparam int TO = 8;

    logic       clk;
    logic       rst;
    logic       in_v, conv_out_v;
    logic       in_ready, lsb_shift, conv_rst, conv_relu, out_v, busy, timeout_err;
    logic [1:0] conv_layer;
    logic [1:0] cache_shift;
    logic [7:0] overrun_cnt;

    logic       in_v_b, conv_out_v_b;
    logic       in_ready_b, lsb_shift_b, conv_rst_b, conv_relu_b, out_v_b, busy_b, timeout_err_b;
    logic [1:0] conv_layer_b;
    logic [1:0] cache_shift_b;
    logic [2:0] overrun_cnt_b;

    int checks;
    int failures;

    conv_layer_scheduler #(.NUM_LAYERS(3), .LW(2), .TIMEOUT(TO), .TW(7), .CW(8)) u_dut (
        .clk(clk), .rst(rst), .in_v(in_v), .in_ready(in_ready), .lsb_shift(lsb_shift),
        .conv_rst(conv_rst), .conv_layer(conv_layer), .conv_relu(conv_relu),
        .conv_out_v(conv_out_v), .cache_shift(cache_shift), .out_v(out_v), .busy(busy),
        .timeout_err(timeout_err), .overrun_cnt(overrun_cnt)
    );

    conv_layer_scheduler #(.CW(3)) u_dut_b (
        .clk(clk), .rst(rst), .in_v(in_v_b), .in_ready(in_ready_b), .lsb_shift(lsb_shift_b),
        .conv_rst(conv_rst_b), .conv_layer(conv_layer_b), .conv_relu(conv_relu_b),
        .conv_out_v(conv_out_v_b), .cache_shift(cache_shift_b), .out_v(out_v_b), .busy(busy_b),
        .timeout_err(timeout_err_b), .overrun_cnt(overrun_cnt_b)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Stimulus schedule and expected timeline, indexed by cycle.
    bit drv_rst [NC];
    bit drv_in_v[NC];
    bit drv_cov [NC];
    bit drv_in_v_b[NC];
    bit busy_e  [NC];
    bit e_lsb   [NC];
    bit e_crst  [NC];
    bit e_outv  [NC];
    bit to_evt  [NC];
    int e_cache [NC];
    int lay_evt [NC];
    int exp_cnt [NC];
    int exp_err [NC];
    int exp_lay [NC];

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, c, act, exp);
        end
    endtask

    // One frame accepted at cycle t; d[k]=0 means the engine never answers in layer k.
    task automatic plan(input int t, input int d0, input int d1, input int d2, input bit hold_start);
        int d[3];
        int c, s, n;
        bit stop;
        d[0] = d0; d[1] = d1; d[2] = d2;
        stop = 0;
        drv_in_v[t] = 1; lay_evt[t] = 0;
        busy_e[t+1] = 1; e_lsb[t+1] = 1;
        c = t + 1;
        for (int k = 0; k < 3; k++) begin
            if (!stop) begin
                s = c + 1;
                e_crst[s] = 1;
                if (hold_start) drv_cov[s] = 1;
                n = (d[k] == 0) ? TO : d[k];
                for (int w = s; w <= s + n; w++) busy_e[w] = 1;
                if (d[k] == 0) begin
                    to_evt[s+n] = 1;
                    stop = 1;
                end else begin
                    drv_cov[s+n] = 1;
                    busy_e[s+n+1] = 1;
                    if (k < 2) begin
                        e_cache[s+n+1] = 1 << k;
                        lay_evt[s+n+1] = k + 1;
                        c = s + n + 1;
                    end else begin
                        e_outv[s+n+1] = 1;
                    end
                end
            end
        end
    endtask

    task automatic apply_reset(input int r);
        drv_rst[r] = 1;
        for (int c = r + 1; c < NC; c++) begin
            busy_e[c] = 0; e_lsb[c] = 0; e_crst[c] = 0; e_outv[c] = 0;
            to_evt[c] = 0; e_cache[c] = 0; lay_evt[c] = -1; drv_cov[c] = 0;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int c = 0; c < NC; c++) begin
            drv_rst[c] = 0; drv_in_v[c] = 0; drv_cov[c] = 0; drv_in_v_b[c] = 0;
            busy_e[c] = 0; e_lsb[c] = 0; e_crst[c] = 0; e_outv[c] = 0; to_evt[c] = 0;
            e_cache[c] = 0; lay_evt[c] = -1;
        end
        drv_rst[0] = 1;
        plan(10, 4, 4, 4, 0);
        for (int c = 40; c <= 64; c++) drv_in_v[c] = 1;
        plan(40, 4, 4, 4, 0);
        plan(60, 4, 4, 4, 0);
        plan(90, 4, 0, 4, 0);
        plan(110, 4, 4, 4, 0);
        plan(140, 4, 4, 4, 0);
        drv_in_v[144] = 1;
        apply_reset(150);
        plan(155, 4, 4, 4, 0);
        plan(180, 8, 8, 8, 1);
        drv_in_v_b[220] = 1;
        for (int j = 0; j < 10; j++) drv_in_v_b[222 + 2*j] = 1;

        // Registers that persist across frames follow from the event timeline.
        exp_cnt[1] = 0; exp_err[1] = 0; exp_lay[1] = 0;
        for (int c = 1; c < NC - 1; c++) begin
            if (drv_rst[c]) begin
                exp_cnt[c+1] = 0; exp_err[c+1] = 0; exp_lay[c+1] = 0;
            end else begin
                exp_cnt[c+1] = (drv_in_v[c] && busy_e[c] && exp_cnt[c] < 255) ? exp_cnt[c] + 1 : exp_cnt[c];
                exp_err[c+1] = exp_err[c] | int'(to_evt[c]);
                exp_lay[c+1] = (lay_evt[c] >= 0) ? lay_evt[c] : exp_lay[c];
            end
        end

        #1;
        for (int c = 0; c < NC; c++) begin
            rst = drv_rst[c];
            in_v = drv_in_v[c];
            conv_out_v = drv_cov[c];
            in_v_b = drv_in_v_b[c];
            conv_out_v_b = 1'b0;
            @(negedge clk);
            if (c >= 1) begin
                chk("in_ready", c, in_ready, !busy_e[c]);
                chk("busy", c, busy, busy_e[c]);
                chk("lsb_shift", c, lsb_shift, e_lsb[c]);
                chk("conv_rst", c, conv_rst, e_crst[c]);
                chk("cache_shift", c, cache_shift, e_cache[c]);
                chk("out_v", c, out_v, e_outv[c]);
                chk("conv_layer", c, conv_layer, exp_lay[c]);
                chk("conv_relu", c, conv_relu, exp_lay[c] != 2);
                chk("timeout_err", c, timeout_err, exp_err[c]);
                chk("overrun_cnt", c, overrun_cnt, exp_cnt[c]);
            end
            case (c)
                1:   begin chk("lit_rst_ready", c, in_ready, 1); chk("lit_rst_cnt_b", c, overrun_cnt_b, 0); end
                11:  chk("lit_s1_lsb", c, lsb_shift, 1);
                12:  chk("lit_s1_crst0", c, conv_rst, 1);
                17:  chk("lit_s1_cache0", c, cache_shift, 2'b01);
                18:  chk("lit_s1_crst1", c, conv_rst, 1);
                19:  begin chk("lit_s1_layer1", c, conv_layer, 1); chk("lit_s1_relu1", c, conv_relu, 1); end
                23:  chk("lit_s1_cache1", c, cache_shift, 2'b10);
                24:  chk("lit_s1_crst2", c, conv_rst, 1);
                25:  begin chk("lit_s1_layer2", c, conv_layer, 2); chk("lit_s1_relu2", c, conv_relu, 0); end
                29:  chk("lit_s1_outv", c, out_v, 1);
                30:  chk("lit_s1_ready", c, in_ready, 1);
                60:  chk("lit_s2_cnt19", c, overrun_cnt, 19);
                65:  chk("lit_s2_cnt23", c, overrun_cnt, 23);
                106: chk("lit_s3_err0", c, timeout_err, 0);
                107: begin chk("lit_s3_err1", c, timeout_err, 1); chk("lit_s3_ready", c, in_ready, 1); end
                129: chk("lit_s3_outv", c, out_v, 1);
                151: begin
                    chk("lit_s5_ready", c, in_ready, 1);
                    chk("lit_s5_layer", c, conv_layer, 0);
                    chk("lit_s5_err", c, timeout_err, 0);
                    chk("lit_s5_cnt", c, overrun_cnt, 0);
                    chk("lit_s5_crst", c, conv_rst, 0);
                end
                156: chk("lit_s5_lsb", c, lsb_shift, 1);
                174: chk("lit_s5_outv", c, out_v, 1);
                211: begin chk("lit_s4_outv", c, out_v, 1); chk("lit_s4_err", c, timeout_err, 0); end
                221: chk("lit_b_lsb", c, lsb_shift_b, 1);
                286: chk("lit_b_err0", c, timeout_err_b, 0);
                287: begin chk("lit_b_err1", c, timeout_err_b, 1); chk("lit_b_ready", c, in_ready_b, 1); end
                default: ;
            endcase
            if (c >= 223 && c <= 241 && ((c - 223) % 2) == 0) begin
                chk("lit_b_sat", c, overrun_cnt_b, ((c - 223) / 2 + 1 > 7) ? 7 : (c - 223) / 2 + 1);
            end
            @(posedge clk);
            #1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
